full_adder: RTL and testbench
=============================

FULL_ADDER -- requirements
Module: full_adder

Interface
REQ-001 SHALL expose parameter CNT_W, default 8, meaning the width of the capture counter (legal range 1..16).
REQ-002 SHALL have port clk, input, 1 bit; the single clock, all state updates on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit; asynchronous active-low reset.
REQ-004 SHALL have port a, input, 1 bit; addend bit.
REQ-005 SHALL have port b, input, 1 bit; addend bit.
REQ-006 SHALL have port cin, input, 1 bit; carry-in bit.
REQ-007 SHALL have port en, input, 1 bit; capture enable for the registered path.
REQ-008 SHALL have port serial_mode, input, 1 bit; 1 means the registered path takes carry-in from carry_q instead of cin.
REQ-009 SHALL have port clr, input, 1 bit; synchronous clear of all registered state.
REQ-010 SHALL have port sum, output, 1 bit; combinational sum.
REQ-011 SHALL have port carry, output, 1 bit; combinational carry-out.
REQ-012 SHALL have port sum_q, output, 1 bit; registered sum.
REQ-013 SHALL have port carry_q, output, 1 bit; registered carry-out.
REQ-014 SHALL have port valid_q, output, 1 bit; high for one cycle after each capture.
REQ-015 SHALL have port count_q, output, CNT_W bits; number of captures, modulo 2^CNT_W.

Function
REQ-016 SHALL drive sum = a XOR b XOR cin, purely combinational with zero cycles of latency.
REQ-017 SHALL drive carry = (a AND b) OR (a AND cin) OR (b AND cin), purely combinational.
REQ-018 SHALL make sum and carry independent of clk, rst_n, en, serial_mode and clr, so they are correct with those ports unconnected.
REQ-019 SHALL define cin_eff = carry_q when serial_mode=1, otherwise cin_eff = cin.
REQ-020 SHALL, on a rising edge with clr=0 and en=1, load sum_q/carry_q with the full-add of a, b and cin_eff, set valid_q=1, and increment count_q.
REQ-021 SHALL, on a rising edge with clr=0 and en=0, hold sum_q, carry_q and count_q, and set valid_q=0.
REQ-022 SHALL, on a rising edge with clr=1, clear sum_q, carry_q, valid_q and count_q to 0; clr has priority over en.
REQ-023 SHALL wrap count_q from 2^CNT_W-1 to 0 without a flag.
REQ-024 SHALL give registered outputs a latency of exactly one clock edge after the capturing edge.
REQ-025 SHALL, in serial_mode, perform LSB-first bit-serial addition: operand bits are applied one per enabled cycle, clr precedes the first bit, and carry_q holds the running carry.

Reset
REQ-026 SHALL, while rst_n=0, immediately force sum_q=0, carry_q=0, valid_q=0 and count_q=0, independent of clk.
REQ-027 SHALL leave the combinational outputs sum and carry unaffected by reset.
REQ-028 SHALL take the first capture on the first rising edge after rst_n deasserts, if en=1; a reset mid-sequence discards the serial carry.

Structure
REQ-029 SHALL need no shared package; CNT_W is the only constant and is a module parameter.
REQ-030 SHALL implement the 1-bit combinational adder as sub-module fa_cell, instantiated twice: once with cin for the combinational path and once with cin_eff for the registered path.

Verification
REQ-031 SHALL cover the exhaustive combinational case: {a,b,cin} = 0..7, each held for 10 time units with clk/rst_n undriven -> sum/carry = 00,10,10,01,10,01,01,11.
REQ-032 SHALL cover reset: assert rst_n=0 mid-cycle with count_q=5 -> all registered outputs 0 immediately, with no clock edge.
REQ-033 SHALL cover capture: en=1 with a=1, b=1, cin=1, serial_mode=0 -> after the edge, sum_q=1, carry_q=1, valid_q=1, count_q=1; then en=0 -> valid_q=0 and values held.
REQ-034 SHALL cover serial addition: clr, then serial_mode=1, en=1, 4 bits LSB-first of 0xB + 0x6 -> sum_q sequence 1,0,0,0, then final carry_q=1 (result 0x11).
REQ-035 SHALL cover counter wrap: with CNT_W=2, apply 5 enabled captures -> count_q = 1,2,3,0,1.
REQ-036 SHALL cover clr priority: clr=1 and en=1 on the same edge -> all registered outputs 0 and count_q=0.

Source files
------------

// File: rtl/fa_cell.sv
// fa_cell: one-bit full adder cell.
// Pure combinational logic. The top instantiates it once for the live
// combinational outputs and once for the value captured into the registers.
module fa_cell (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  // Sum is the parity of the three inputs; carry is their majority.
  always_comb begin
    sum   = a ^ b ^ cin;
    carry = (a & b) | (a & cin) | (b & cin);
  end

endmodule

// File: rtl/full_adder.sv
// full_adder: one-bit full adder with a combinational path and a registered
// capture path.
//
// Combinational path: sum/carry come from a, b, cin only. They never depend
// on the clock, reset or control inputs, so they stay usable when those
// ports are left unconnected.
//
// Registered path: on each enabled edge, sum_q/carry_q capture the full-add
// of a, b and cin_eff. valid_q pulses for one cycle after each capture, and
// count_q counts captures modulo 2^CNT_W, wrapping silently.
//
// Serial mode: cin_eff is taken from carry_q, so operand bits applied
// LSB-first, one per enabled cycle, form a bit-serial adder. The running
// carry lives in carry_q. Pulse clr before the first bit to zero it.
//
// Control priority: rst_n (asynchronous) over clr (synchronous) over en.
module full_adder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a,
  input  logic             b,
  input  logic             cin,
  input  logic             en,
  input  logic             serial_mode,
  input  logic             clr,
  output logic             sum,
  output logic             carry,
  output logic             sum_q,
  output logic             carry_q,
  output logic             valid_q,
  output logic [CNT_W-1:0] count_q
);

  localparam logic [CNT_W-1:0] COUNT_ONE = CNT_W'(1);

  logic cin_eff;
  logic sum_r;
  logic carry_r;

  // Combinational adder fed directly by the cin port.
  fa_cell u_fa_comb (
    .a     (a),
    .b     (b),
    .cin   (cin),
    .sum   (sum),
    .carry (carry)
  );

  // In serial mode the carry-in comes from the previous capture.
  always_comb begin
    cin_eff = serial_mode ? carry_q : cin;
  end

  // Adder feeding the capture registers.
  fa_cell u_fa_reg (
    .a     (a),
    .b     (b),
    .cin   (cin_eff),
    .sum   (sum_r),
    .carry (carry_r)
  );

  // Capture registers: async reset, then sync clear, then enabled load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else if (clr) begin
      sum_q   <= 1'b0;
      carry_q <= 1'b0;
      valid_q <= 1'b0;
      count_q <= '0;
    end else if (en) begin
      sum_q   <= sum_r;
      carry_q <= carry_r;
      valid_q <= 1'b1;
      count_q <= count_q + COUNT_ONE;
    end else begin
      valid_q <= 1'b0;
    end
  end

endmodule

// File: tb/tb_full_adder.sv
// tb_full_adder: randomized, self-checking bench for full_adder.
//
// Two instances share every input:
//   dut    - default 8-bit counter
//   dut_w2 - 2-bit counter, used to exercise wrap-around
//
// The driver applies inputs on the falling edge. It then advances an
// arithmetic reference model and pushes the expected registered state into
// exp_q. A monitor pops exp_q one step after each rising edge and compares
// against both instances. Combinational outputs are checked directly by
// the driver.
module tb_full_adder;

  localparam int EW = 13;  // {sum_q, carry_q, valid_q, count8[7:0], count2[1:0]}

  logic       clk;
  logic       clk_run;
  logic       rst_n;
  logic       a, b, cin, en, serial_mode, clr;
  logic       sum, carry, sum_q, carry_q, valid_q;
  logic [7:0] count_q;
  logic       sum_w2, carry_w2, sum_q_w2, carry_q_w2, valid_q_w2;
  logic [1:0] count_q_w2;

  int errors = 0;
  int checks = 0;

  logic [EW-1:0] exp_q[$];

  // Reference model state: plain integers.
  int m_sum, m_carry, m_cnt;

  full_adder #(.CNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .en(en),
    .serial_mode(serial_mode), .clr(clr), .sum(sum), .carry(carry),
    .sum_q(sum_q), .carry_q(carry_q), .valid_q(valid_q), .count_q(count_q)
  );

  full_adder #(.CNT_W(2)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .cin(cin), .en(en),
    .serial_mode(serial_mode), .clr(clr), .sum(sum_w2), .carry(carry_w2),
    .sum_q(sum_q_w2), .carry_q(carry_q_w2), .valid_q(valid_q_w2),
    .count_q(count_q_w2)
  );

  // ---------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------

  // Clock toggles only once clk_run is set, so the combinational phase
  // runs with no clock activity.
  initial begin
    clk     = 1'b0;
    clk_run = 1'b0;
    forever begin
      #5;
      if (clk_run) clk = ~clk;
    end
  end

  // ---------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [EW-1:0] model_vec(input int valid);
    logic [7:0] c8;
    logic [1:0] c2;
    c8 = 8'(m_cnt % 256);
    c2 = 2'(m_cnt % 4);
    return {1'(m_sum), 1'(m_carry), 1'(valid), c8, c2};
  endfunction

  // ---------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------

  // Drive one clock cycle of inputs, check the combinational outputs,
  // and push the expected post-edge register state.
  task automatic drive(input logic ia, input logic ib, input logic icin,
                       input logic ien, input logic ism, input logic iclr);
    int cin_e;
    int total;
    int v;
    @(negedge clk);
    a = ia; b = ib; cin = icin; en = ien; serial_mode = ism; clr = iclr;
    #1;
    total = int'(ia) + int'(ib) + int'(icin);
    check("comb_sum",      {31'd0, sum},      32'(total % 2));
    check("comb_carry",    {31'd0, carry},    32'(total / 2));
    check("comb_sum_w2",   {31'd0, sum_w2},   32'(total % 2));
    check("comb_carry_w2", {31'd0, carry_w2}, 32'(total / 2));
    v = 0;
    if (iclr) begin
      m_sum = 0; m_carry = 0; m_cnt = 0;
    end else if (ien) begin
      cin_e = ism ? m_carry : int'(icin);
      total = int'(ia) + int'(ib) + cin_e;
      m_sum   = total % 2;
      m_carry = total / 2;
      m_cnt   = m_cnt + 1;
      v = 1;
    end
    exp_q.push_back(model_vec(v));
  endtask

  // Check that every registered output of both instances reads zero.
  task automatic check_regs_zero(input string tag);
    check({tag, "_sum_q"},   {31'd0, sum_q},   32'd0);
    check({tag, "_carry_q"}, {31'd0, carry_q}, 32'd0);
    check({tag, "_valid_q"}, {31'd0, valid_q}, 32'd0);
    check({tag, "_count_q"}, {24'd0, count_q}, 32'd0);
    check({tag, "_w2_all"},
          {27'd0, sum_q_w2, carry_q_w2, valid_q_w2, count_q_w2}, 32'd0);
  endtask

  // ---------------------------------------------------------------------
  // Monitor / scoreboard
  // ---------------------------------------------------------------------

  // Compares registered state after each rising edge whenever an
  // expectation is pending.
  initial begin
    logic [EW-1:0] e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("reg_sum_q",      {31'd0, sum_q},      {31'd0, e[12]});
        check("reg_carry_q",    {31'd0, carry_q},    {31'd0, e[11]});
        check("reg_valid_q",    {31'd0, valid_q},    {31'd0, e[10]});
        check("reg_count_q",    {24'd0, count_q},    {24'd0, e[9:2]});
        check("reg_sum_q_w2",   {31'd0, sum_q_w2},   {31'd0, e[12]});
        check("reg_carry_q_w2", {31'd0, carry_q_w2}, {31'd0, e[11]});
        check("reg_valid_q_w2", {31'd0, valid_q_w2}, {31'd0, e[10]});
        check("reg_count_q_w2", {30'd0, count_q_w2}, {30'd0, e[1:0]});
      end
    end
  end

  // ---------------------------------------------------------------------
  // Main stimulus
  // ---------------------------------------------------------------------

  initial begin
    logic [3:0] op_a;
    logic [3:0] op_b;
    logic [4:0] ser_res;
    int         total;
    int         budget;

    m_sum = 0; m_carry = 0; m_cnt = 0;

    // Exhaustive combinational sweep with no clock running and rst_n
    // never driven.
    for (int i = 0; i < 8; i++) begin
      a   = 1'(i >> 2);
      b   = 1'(i >> 1);
      cin = 1'(i);
      #10;
      total = (i >> 2) % 2 + (i >> 1) % 2 + i % 2;
      check("exh_sum",   {31'd0, sum},   32'(total % 2));
      check("exh_carry", {31'd0, carry}, 32'(total / 2));
    end

    // Reset takes effect immediately, with no clock edge.
    en = 1'b0; clr = 1'b0; serial_mode = 1'b0;
    rst_n = 1'b0;
    #1;
    check_regs_zero("reset_init");

    clk_run = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Capture a=b=cin=1, then hold with en=0.
    drive(1, 1, 1, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);

    // Bring count to 5, then assert reset mid-cycle.
    repeat (4) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1, 0, 0);
    @(posedge clk);
    #3;
    check("pre_reset_count", {24'd0, count_q}, 32'd5);
    en = 1'b0; clr = 1'b0;
    rst_n = 1'b0;
    #1;
    check_regs_zero("reset_mid");
    m_sum = 0; m_carry = 0; m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;

    // clr wins over en on the same edge.
    drive(1, 1, 0, 1, 0, 0);
    drive(1, 0, 1, 1, 0, 0);
    drive(1, 1, 1, 1, 0, 1);

    // Bit-serial 0xB + 0x6, LSB first.
    op_a = 4'hB;
    op_b = 4'h6;
    drive(0, 0, 0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      drive(op_a[i], op_b[i], 1'($urandom_range(0, 1)), 1, 1, 0);
      @(posedge clk);
      #2;
      ser_res[i] = sum_q;
    end
    ser_res[4] = carry_q;
    check("serial_result", {27'd0, ser_res}, 32'(int'(op_a) + int'(op_b)));

    // Counter wrap: five captures after clr.
    drive(0, 0, 0, 0, 0, 1);
    repeat (5) drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                     1'($urandom_range(0, 1)), 1, 0, 0);
    @(posedge clk);
    #3;
    check("wrap_count_w2", {30'd0, count_q_w2}, 32'd1);

    // Randomized traffic, with occasional clears.
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 3) != 0),
            1'($urandom_range(0, 1)), 1'($urandom_range(0, 15) == 0));
    end
    drive(0, 0, 0, 0, 0, 0);

    // Drain the scoreboard within a bounded number of cycles.
    budget = 20;
    while (exp_q.size() > 0 && budget > 0) begin
      @(posedge clk);
      budget--;
    end
    #3;
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
